pdm_mic_rx: RTL



---
 rtl/pdm_mic_pkg.sv | 18 +
 rtl/pdm_sample_fifo.sv | 67 ++++++
 rtl/pdm_mic_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pdm_mic_pkg.sv
// pdm_mic_pkg: shared constants and helpers for the PDM microphone receive path.
//   PCM_W            width of the PCM samples handed to the core
//   PCM_MAX/PCM_MIN  signed 16-bit full-scale limits
//   shift_for()      left shift that maps a boxcar result onto full-scale PCM
package pdm_mic_pkg;

    localparam int unsigned PCM_W = 16;

    localparam logic [PCM_W-1:0] PCM_MAX = 16'h7FFF;
    localparam logic [PCM_W-1:0] PCM_MIN = 16'h8000;

    // A block of DECIM bits yields raw in [-DECIM, +DECIM]; shifting by this amount
    // puts -DECIM exactly on -32768.
    function automatic int unsigned shift_for(input int unsigned decim);
        return 15 - $clog2(decim);
    endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// pdm_sample_fifo: first-word fall-through FIFO for PCM samples.
//   clk, rst   core clock, asynchronous active-high reset
//   push/wdata write a word; ignored while full unless a pop happens in the same cycle
//   pop        consume the head; ignored while empty
//   rdata      head word, driven to zero while empty
//   full/empty occupancy flags
//   level      number of stored words (0..DEPTH)
module pdm_sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata = empty ? '0 : mem_q[rptr_q];
    assign level = level_q;

endmodule

// File: rtl/pdm_mic_rx.sv
// pdm_mic_rx: receive path for the on-board PDM MEMS microphone.
// Generates the mic bit clock, samples the 1-bit stream on the falling mic-clock
// toggle, boxcar-decimates DECIM bits into one signed 16-bit PCM sample and queues
// samples in a FWFT FIFO.
//   clk, rst     core clock, asynchronous active-high reset
//   i_en         capture enable; low clears the front end, FIFO stays readable
//   o_mic_clk    PDM bit clock, clk / (2*CLK_HALF)
//   o_mic_lrsel  channel select, constant 0 (data valid after rising mic edge)
//   i_mic_data   asynchronous PDM data from the microphone
//   o_sample     FIFO head (signed PCM), o_valid = FIFO not empty
//   i_ready      pops the head when o_valid is high
//   o_level      FIFO occupancy
//   o_overflow   sticky drop flag, cleared by i_clr_ovf (a new drop wins)
module pdm_mic_rx
    import pdm_mic_pkg::*;
#(
    parameter int unsigned CLK_HALF   = 25,
    parameter int unsigned DECIM      = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    output logic                          o_mic_clk,
    output logic                          o_mic_lrsel,
    input  logic                          i_mic_data,
    output logic [PCM_W-1:0]              o_sample,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    input  logic                          i_clr_ovf
);

    localparam int unsigned DIV_W  = $clog2(CLK_HALF);
    localparam int unsigned LOG2D  = $clog2(DECIM);
    localparam int unsigned ONES_W = LOG2D + 1;
    localparam int unsigned SHIFT  = shift_for(DECIM);

    // Mic clock divider
    logic [DIV_W-1:0] div_q;
    logic             mic_clk_q;
    logic             div_tc;

    assign div_tc = (div_q == DIV_W'(CLK_HALF - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            mic_clk_q <= 1'b0;
        end else if (!i_en) begin
            div_q     <= '0;
            mic_clk_q <= 1'b0;
        end else if (div_tc) begin
            div_q     <= '0;
            mic_clk_q <= ~mic_clk_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Synchroniser for the asynchronous PDM input
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else if (!i_en) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], i_mic_data};
        end
    end

    // Sampling on the falling toggle leaves about half a mic period of settle time
    // after the rising edge at which the microphone drives its bit.
    logic strobe;
    logic bit_in;

    assign strobe = i_en && div_tc && mic_clk_q;
    assign bit_in = sync_q[1];

    // Boxcar decimator
    logic [ONES_W-1:0] ones_q;
    logic [LOG2D-1:0]  bcnt_q;
    logic [PCM_W-1:0]  pcm_q;
    logic              pcm_vld_q;
    logic [ONES_W-1:0] ones_total;
    logic              last_bit;
    int                raw;
    logic [PCM_W-1:0]  pcm_next;

    assign last_bit = (bcnt_q == LOG2D'(DECIM - 1));

    always_comb begin
        ones_total = ones_q + ONES_W'(bit_in);
        raw        = 2 * int'(ones_total) - int'(DECIM);
        // +DECIM would land one past the positive limit, so it saturates.
        if (raw == int'(DECIM)) begin
            pcm_next = PCM_MAX;
        end else if (raw == -int'(DECIM)) begin
            pcm_next = PCM_MIN;
        end else begin
            pcm_next = PCM_W'(raw <<< SHIFT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q    <= '0;
            bcnt_q    <= '0;
            pcm_q     <= '0;
            pcm_vld_q <= 1'b0;
        end else begin
            pcm_vld_q <= 1'b0;
            if (!i_en) begin
                // Partial block is discarded.
                ones_q <= '0;
                bcnt_q <= '0;
            end else if (strobe) begin
                if (last_bit) begin
                    ones_q    <= '0;
                    bcnt_q    <= '0;
                    pcm_q     <= pcm_next;
                    pcm_vld_q <= 1'b1;
                end else begin
                    ones_q <= ones_total;
                    bcnt_q <= bcnt_q + 1'b1;
                end
            end
        end
    end

    // Sample FIFO and overflow flag
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic drop;
    logic ovf_q;

    assign fifo_pop = i_ready && !fifo_empty;
    assign drop     = pcm_vld_q && fifo_full && !fifo_pop;

    pdm_sample_fifo #(
        .WIDTH (PCM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pcm_vld_q),
        .wdata (pcm_q),
        .pop   (fifo_pop),
        .rdata (o_sample),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign o_mic_clk   = mic_clk_q;
    assign o_mic_lrsel = 1'b0;
    assign o_valid     = !fifo_empty;
    assign o_overflow  = ovf_q;

endmodule
